// File: rtl/rf_write_port_arbiter_if.sv
// rtl/rf_write_port_arbiter_if.sv - signal bundle shared by writeback, aux requester and register-file write port
interface rf_write_port_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [4:0]    aux_rd;
  logic [31:0]   aux_data;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wdata;
  logic          stall_req;
  logic [CW-1:0] fifo_count;
  logic          err_pc_write;

  modport slave (
    input  wb_valid, wb_rd, wb_data, aux_valid, aux_rd, aux_data,
    output aux_ready, rf_we, rf_rd, rf_wdata, stall_req, fifo_count, err_pc_write
  );

  modport master (
    output wb_valid, wb_rd, wb_data, aux_valid, aux_rd, aux_data,
    input  aux_ready, rf_we, rf_rd, rf_wdata, stall_req, fifo_count, err_pc_write
  );
endinterface

// File: rtl/rf_write_port_arbiter.sv
// rtl/rf_write_port_arbiter.sv - register-file write port shared by writeback (priority) and a FIFO-buffered aux requester
module rf_write_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  rf_write_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);
  localparam logic [4:0]    R_ZERO  = 5'd0;
  localparam logic [4:0]    R_PC    = 5'd31;

  logic [36:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] age;

  logic        aux_ready;
  logic        aux_acc;
  logic        push;
  logic        pop;
  logic        wb_legal;
  logic        pc_err;
  logic        rf_we_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_wdata_q;
  logic        stall_q;
  logic        err_q;

  // Handshake completes for r0/r31 too; those requests are simply not enqueued.
  always_comb begin
    aux_ready = !rst && (count < FULL);
    aux_acc   = bus.aux_valid && aux_ready;
    push      = aux_acc && (bus.aux_rd != R_ZERO) && (bus.aux_rd != R_PC);
    wb_legal  = bus.wb_valid && (bus.wb_rd != R_ZERO) && (bus.wb_rd != R_PC);
    pop       = !wb_legal && (count != '0);
    pc_err    = (bus.wb_valid && (bus.wb_rd == R_PC)) || (aux_acc && (bus.aux_rd == R_PC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.aux_rd, bus.aux_data};
  end

  // rf_rd/rf_wdata keep their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else if (wb_legal) begin
      rf_we_q    <= 1'b1;
      rf_rd_q    <= bus.wb_rd;
      rf_wdata_q <= bus.wb_data;
    end else if (pop) begin
      rf_we_q                <= 1'b1;
      {rf_rd_q, rf_wdata_q}  <= mem[rd_ptr];
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age     <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= pc_err;
      stall_q <= (age >= AGE_MAX);
      if ((count == '0) || pop)  age <= '0;
      else if (age < AGE_MAX)    age <= age + AW'(1);
    end
  end

  assign bus.aux_ready    = aux_ready;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_rd        = rf_rd_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.stall_req    = stall_q;
  assign bus.fifo_count   = count;
  assign bus.err_pc_write = err_q;
endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// tb/tb_rf_write_port_arbiter.sv - scoreboard bench for rf_write_port_arbiter
module tb_rf_write_port_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;

  rf_write_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  rf_write_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (chk_en && bus.rf_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rf_write_unexpected: got rd=%0d data=%h, expected no write", bus.rf_rd, bus.rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.rf_rd, bus.rf_wdata} !== mon_e) begin
          n_err++;
          $display("FAIL rf_write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   bus.rf_rd, bus.rf_wdata, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    bus.aux_valid = 1'b1; bus.aux_rd = 5'd9; bus.aux_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      n_cmp++; if (bus.aux_ready !== 1'b0) begin n_err++; $display("FAIL reset_aux_ready: got %b, expected 0", bus.aux_ready); end
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b, expected 0", bus.rf_we); end
      n_cmp++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d, expected 0", bus.fifo_count); end
      n_cmp++; if (bus.stall_req !== 1'b0 || bus.err_pc_write !== 1'b0) begin n_err++; $display("FAIL reset_flags: got stall=%b err=%b, expected 0 0", bus.stall_req, bus.err_pc_write); end
    end
    n_cmp++; if (bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_rf_data: got rd=%0d data=%h, expected 0 0", bus.rf_rd, bus.rf_wdata); end
    rst = 1'b0;
    bus.aux_valid = 1'b0;
    #1;
    n_cmp++; if (bus.aux_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_aux_ready: got %b, expected 1", bus.aux_ready); end
  endtask

  task automatic test_wb_only();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hA5;
    exp_q.push_back({5'd5, 32'hA5});
    tick();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hA5) begin n_err++; $display("FAIL wb_write: got we=%b rd=%0d data=%h, expected 1 5 a5", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
    bus.wb_rd = 5'd0; bus.wb_data = 32'h77;
    tick();
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.err_pc_write !== 1'b0) begin n_err++; $display("FAIL wb_r0_drop: got we=%b err=%b, expected 0 0", bus.rf_we, bus.err_pc_write); end
    n_cmp++; if (bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hA5) begin n_err++; $display("FAIL wb_hold: got rd=%0d data=%h, expected 5 a5", bus.rf_rd, bus.rf_wdata); end
    bus.wb_valid = 1'b0;
    tick();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wb_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    logic [31:0] wd;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h1000;
    exp_q.push_back({5'd2, 32'h1000});
    bus.aux_valid = 1'b1; bus.aux_rd = 5'd8; bus.aux_data = 32'h11;
    #1;
    n_cmp++; if (bus.aux_ready !== 1'b1) begin n_err++; $display("FAIL cont_aux_ready: got %b, expected 1", bus.aux_ready); end
    tick();
    bus.aux_valid = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL cont_count: got %0d, expected 1", bus.fifo_count); end
    for (int k = 1; k <= MAX_WAIT + 1; k++) begin
      wd = 32'h1000 + 32'(k);
      bus.wb_data = wd;
      exp_q.push_back({5'd2, wd});
      tick();
      n_cmp++; if (bus.stall_req !== (k > MAX_WAIT)) begin n_err++; $display("FAIL cont_stall_k%0d: got %b, expected %b", k, bus.stall_req, (k > MAX_WAIT)); end
      n_cmp++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL cont_count_k%0d: got %0d, expected 1", k, bus.fifo_count); end
    end
    bus.wb_valid = 1'b0;
    exp_q.push_back({5'd8, 32'h11});
    tick();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd8 || bus.rf_wdata !== 32'h11) begin n_err++; $display("FAIL cont_aux_write: got we=%b rd=%0d data=%h, expected 1 8 11", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.stall_req !== 1'b1) begin n_err++; $display("FAIL cont_after_pop: got count=%0d stall=%b, expected 0 1", bus.fifo_count, bus.stall_req); end
    tick();
    n_cmp++; if (bus.stall_req !== 1'b0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL cont_stall_clear: got stall=%b we=%b, expected 0 0", bus.stall_req, bus.rf_we); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL cont_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_full();
    int  m = 0;
    int  sent = 0;
    bit  busy;
    bit  acc;
    bit  pop;
    logic [31:0] wd;
    for (int cyc = 0; cyc < 20; cyc++) begin
      busy = (cyc < 7);
      wd = 32'h300 + 32'(cyc);
      bus.wb_valid = busy; bus.wb_rd = 5'd3; bus.wb_data = wd;
      if (busy) exp_q.push_back({5'd3, wd});
      if (cyc == 7)
        for (int j = 0; j < 5; j++) exp_q.push_back({5'(10 + j), 32'h200 + 32'(j)});
      bus.aux_valid = (sent < 5);
      bus.aux_rd = 5'(10 + sent);
      bus.aux_data = 32'h200 + 32'(sent);
      #1;
      n_cmp++; if (bus.aux_ready !== (m < DEPTH)) begin n_err++; $display("FAIL full_aux_ready_c%0d: got %b, expected %b", cyc, bus.aux_ready, (m < DEPTH)); end
      acc = (sent < 5) && (m < DEPTH);
      pop = !busy && (m > 0);
      tick();
      m = m + int'(acc) - int'(pop);
      if (acc) sent++;
      n_cmp++; if (bus.fifo_count !== 3'(m)) begin n_err++; $display("FAIL full_count_c%0d: got %0d, expected %0d", cyc, bus.fifo_count, m); end
    end
    bus.aux_valid = 1'b0; bus.wb_valid = 1'b0;
    tick();
    n_cmp++; if (exp_q.size() != 0 || sent != 5) begin n_err++; $display("FAIL full_drain: got %0d pending %0d sent, expected 0 5", exp_q.size(), sent); end
  endtask

  task automatic test_pc_guard();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd31; bus.wb_data = 32'hBAD0;
    bus.aux_valid = 1'b1; bus.aux_rd = 5'd31; bus.aux_data = 32'hBAD1;
    #1;
    n_cmp++; if (bus.aux_ready !== 1'b1) begin n_err++; $display("FAIL pc_aux_ready: got %b, expected 1", bus.aux_ready); end
    tick();
    bus.wb_valid = 1'b0; bus.aux_valid = 1'b0;
    n_cmp++; if (bus.err_pc_write !== 1'b1 || bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL pc_reject: got err=%b we=%b count=%0d, expected 1 0 0", bus.err_pc_write, bus.rf_we, bus.fifo_count); end
    tick();
    n_cmp++; if (bus.err_pc_write !== 1'b0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL pc_single_pulse: got err=%b we=%b, expected 0 0", bus.err_pc_write, bus.rf_we); end
    bus.aux_valid = 1'b1; bus.aux_rd = 5'd0; bus.aux_data = 32'h5;
    tick();
    bus.aux_valid = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.err_pc_write !== 1'b0) begin n_err++; $display("FAIL aux_r0_drop: got count=%0d err=%b, expected 0 0", bus.fifo_count, bus.err_pc_write); end
    tick();
    n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL aux_r0_nowrite: got %b, expected 0", bus.rf_we); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    for (int i = 0; i < 3; i++) begin
      wd = 32'h400 + 32'(i);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = wd;
      exp_q.push_back({5'd4, wd});
      bus.aux_valid = 1'b1; bus.aux_rd = 5'(20 + i); bus.aux_data = 32'h600 + 32'(i);
      tick();
    end
    bus.aux_valid = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_queued: got %0d, expected 3", bus.fifo_count); end
    rst = 1'b1; bus.wb_data = 32'h4FF;
    tick();
    rst = 1'b0; bus.wb_valid = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL mid_reset: got count=%0d we=%b, expected 0 0", bus.fifo_count, bus.rf_we); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL mid_flushed_c%0d: got we=%b count=%0d, expected 0 0", i, bus.rf_we, bus.fifo_count); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    bus.aux_valid = 1'b0; bus.aux_rd = 5'd0; bus.aux_data = 32'h0;
    test_reset();
    test_wb_only();
    test_contention();
    test_full();
    test_pc_guard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
